router_switch_allocator: RTL
============================

Name: router_switch_allocator

Overview:
Packet-level round-robin switch allocator for one mesh router. It shares the router's single arbiter-to-routing datapath among the REN input queues and locks a grant for a whole packet, head flit through tail flit. The routing stage supplies the destination output port of each queue's head flit, and the allocator pops flits only when that output signals availability. It sits between the per-port input queues (pop strobes) and the XY routing/output stage (selected input index, latched output port).

Parameters:
N, 5, number of requesters/output ports (REN: local, N, E, S, W)
IW, 3, index width for requester and port numbers (REN_B)
STALL_MAX, 255, locked cycles without a pop before stall_err sets

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N  req[i]=1: queue i has a valid head flit
req_port  in  N*IW  destination output port of queue i head flit, slice i = [i*IW +: IW]
req_tail  in  N  head flit of queue i is a packet tail; a single-flit packet has head=tail
out_ready  in  N  downstream availability per output port
grant_valid  out  1  a packet is locked to grant_idx
grant_idx  out  IW  granted input queue; drives the datapath select
route_port  out  IW  output port latched at grant time
pop  out  N  one-hot shift strobe to input queues; a flit transfers this cycle
stall_err  out  1  sticky: lock exceeded STALL_MAX idle cycles
bad_dest  out  1  sticky: a requester presented req_port >= N

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset rst_n. Reset values: state IDLE, ptr=0, grant_valid=0, grant_idx=0, route_port=0, stall_err=0, bad_dest=0, stall counter=0. pop is combinational from registered state and is 0 immediately when rst_n asserts, including mid-packet. The interrupted packet is abandoned and the queues must be reset together with the allocator.
- FSM states: IDLE and LOCKED.
- IDLE:
  - Eligible requesters: req[i]=1 and req_port[i]<N.
  - Scan starts at ptr and proceeds ptr, ptr+1, ..., wrapping modulo N. The first eligible i wins.
  - On a winner, at the next edge: state=LOCKED, grant_valid=1, grant_idx=i, route_port=req_port[i].
  - With no winner, the allocator stays in IDLE. pop is always 0 in IDLE.
- LOCKED:
  - pop[grant_idx] = req[grant_idx] & out_ready[route_port]. All other pop bits are 0.
  - route_port is frozen for the whole packet. Changes on req_port are ignored while locked.
  - If pop fires and req_tail[grant_idx]=1, then at the edge: state=IDLE, grant_valid=0, ptr=(grant_idx+1) mod N. The released port gets lowest priority next round.
  - If req[grant_idx] drops mid-packet (queue underflow between flits), the allocator holds the lock and waits with no pop. Other requesters stay blocked; wormhole semantics.
  - A pop with req_tail=0 keeps the lock.
- Latency:
  - Request to grant_valid: 1 cycle.
  - Grant to first pop: 0 cycles if out_ready is already high.
  - After a tail pop there is exactly 1 IDLE bubble cycle before the next grant registers. Per-packet overhead is 2 cycles beyond flit count.
- Stall counter:
  - Counts LOCKED cycles with pop=0 and resets to 0 on any pop or on release. It saturates at STALL_MAX.
  - On reaching STALL_MAX, stall_err sets and stays set until reset. The lock is not released.
- bad_dest: sets, sticky, whenever in IDLE some req[i]=1 with req_port[i]>=N. That requester is skipped.
- Simultaneous events:
  - Tail pop and a new request from the same queue in the same cycle: the new request competes normally next IDLE cycle from the advanced ptr.
  - When req and out_ready change in the same cycle, the pop decision uses current-cycle values.
- Wrap-around: ptr stays in 0..N-1. From grant_idx=N-1, release sets ptr=0.

Test Plan:
- Reset then req=5'b00100, req_port[2]=3, req_tail[2]=1, out_ready=all 1 -> grant_valid=1, grant_idx=2, route_port=3 one cycle later; pop=5'b00100 for 1 cycle; grant_valid=0 next cycle; ptr=3.
- All five requesting single-flit packets continuously, all ready -> grant order 0,1,2,3,4,0; one pop every 3 cycles; no requester granted twice before all others.
- Queue 1 sends a 4-flit packet (tail on flit 4) while queue 0 also requests, out_ready[port] toggled 1,0,1,1,0,1 -> exactly 4 pops on pop[1] only, during ready cycles; pop[0] stays 0 until the cycle after queue 1's tail pop plus the grant cycle.
- Locked grant, req[grant_idx] drops for 3 cycles mid-packet -> no pop, grant held, no other grant; resumes popping when req returns.
- Locked, out_ready held 0 with STALL_MAX=8 -> stall_err=1 on the 8th idle locked cycle, still LOCKED; clears only on rst_n=0.
- rst_n pulsed low mid-packet (asynchronous, between edges) -> pop=0 and grant_valid=0 immediately; req_port[0]=7 presented afterwards -> bad_dest=1, requester 0 never granted.

Source files
------------

// File: rtl/router_switch_allocator_if.sv
// Handshake bundle between the per-port input queues / routing stage and the switch allocator.
// Latency: none, wires only.
// Backpressure: out_ready per output port gates pop; pop is the only transfer strobe.
// Ports: req/req_port/req_tail/out_ready flow queue->allocator; grant_valid/grant_idx/
//        route_port/pop/stall_err/bad_dest flow allocator->datapath and queues.
interface router_switch_allocator_if #(
  parameter int N  = 5,
  parameter int IW = 3
);
  logic [N-1:0]    req;
  logic [N*IW-1:0] req_port;
  logic [N-1:0]    req_tail;
  logic [N-1:0]    out_ready;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   route_port;
  logic [N-1:0]    pop;
  logic            stall_err;
  logic            bad_dest;

  // master: the allocator itself
  modport master (
    input  req, req_port, req_tail, out_ready,
    output grant_valid, grant_idx, route_port, pop, stall_err, bad_dest
  );

  // slave: the queues / routing stage around it
  modport slave (
    output req, req_port, req_tail, out_ready,
    input  grant_valid, grant_idx, route_port, pop, stall_err, bad_dest
  );
endinterface

// File: rtl/router_switch_allocator.sv
// Packet-level round-robin switch allocator: locks one input queue from head to tail flit.
// Latency: request to grant 1 cycle; pop is combinational in the locked state; 1 dead cycle after release.
// Backpressure: pop[grant_idx] fires only when the locked queue has a flit and out_ready[route_port] is high.
// Ports: clk, rst_n (async active-low), bus (master modport: requests in, grant/pop/error flags out).
module router_switch_allocator #(
  parameter int N         = 5,
  parameter int IW        = 3,
  parameter int STALL_MAX = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  router_switch_allocator_if.master   bus
);

  localparam int            SW        = $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic          bubble;
  logic [SW-1:0] stall_cnt;
  logic          grant_valid_q;
  logic [IW-1:0] grant_idx_q;
  logic [IW-1:0] route_port_q;
  logic          stall_err_q;
  logic          bad_dest_q;

  logic [IW-1:0] port_of [N];
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] win_port;
  logic          any_bad;
  logic [N-1:0]  pop_vec;
  logic          pop_any;

  for (genvar g = 0; g < N; g++) begin : g_port
    assign port_of[g] = bus.req_port[g*IW +: IW];
  end

  // Round-robin scan starting at ptr; requesters aimed at a nonexistent port are skipped.
  always_comb begin
    int            j;
    logic [IW-1:0] j_idx;
    j         = 0;
    j_idx     = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_port  = '0;
    any_bad   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i] && int'(port_of[i]) >= N) any_bad = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      j_idx = IW'(j);
      if (!win_found && bus.req[j_idx] && int'(port_of[j_idx]) < N) begin
        win_found = 1'b1;
        win_idx   = j_idx;
        win_port  = port_of[j_idx];
      end
    end
  end

  // Only the locked queue may shift, and only when its latched output can accept a flit.
  always_comb begin
    pop_vec = '0;
    if (state == LOCKED && bus.req[grant_idx_q] && bus.out_ready[route_port_q])
      pop_vec[grant_idx_q] = 1'b1;
  end
  assign pop_any = |pop_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      bubble        <= 1'b0;
      stall_cnt     <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      route_port_q  <= '0;
      stall_err_q   <= 1'b0;
      bad_dest_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (any_bad) bad_dest_q <= 1'b1;
          // The cycle right after a release is dead: arbitration resumes one cycle later.
          if (bubble) begin
            bubble <= 1'b0;
          end else if (win_found) begin
            state         <= LOCKED;
            grant_valid_q <= 1'b1;
            grant_idx_q   <= win_idx;
            route_port_q  <= win_port;
          end
        end
        LOCKED: begin
          if (pop_any) begin
            stall_cnt <= '0;
            if (bus.req_tail[grant_idx_q]) begin
              state         <= IDLE;
              grant_valid_q <= 1'b0;
              bubble        <= 1'b1;
              // Released queue drops to lowest priority for the next round.
              ptr           <= (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
            end
          end else if (stall_cnt != STALL_LIM) begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt + 1'b1 == STALL_LIM) stall_err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.route_port  = route_port_q;
  assign bus.pop         = pop_vec;
  assign bus.stall_err   = stall_err_q;
  assign bus.bad_dest    = bad_dest_q;

endmodule
